management: RTL and testbench

MANAGEMENT -- requirements
Module: management

---
 rtl/management.sv | 178 +++++++++++++++++
 tb/tb_management.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/management.sv
// Elevator controller: keypad strobe synchroniser, floor-request latch and a
// four-state travel/door FSM. Define MANAGEMENT_SEG7_EN to drive seg_out from current_floor.
module management #(
    parameter int unsigned NUM_FLOORS    = 9,
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       my_clock,
    input  logic [4:1] BCD_input,
    output logic [3:0] current_floor,
    output logic       moving_up,
    output logic       moving_down,
    output logic       door_open,
    output logic [9:1] pending,
    output logic [6:0] seg_out
);
    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

    localparam logic [3:0] TOP_FLOOR   = 4'(NUM_FLOORS);
    localparam logic [7:0] TRAVEL_LAST = 8'(TRAVEL_CYCLES - 1);
    localparam logic [7:0] DOOR_LAST   = 8'(DOOR_CYCLES - 1);

    function automatic logic [9:1] onehot(input logic [3:0] f);
        logic [9:1] v;
        v = '0;
        for (int unsigned i = 1; i <= 9; i++)
            if (f == 4'(i)) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic any_above(input logic [9:1] p, input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int unsigned i = 1; i <= 9; i++)
            if (p[i] && 4'(i) > f) r = 1'b1;
        return r;
    endfunction

    function automatic logic any_below(input logic [9:1] p, input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int unsigned i = 1; i <= 9; i++)
            if (p[i] && 4'(i) < f) r = 1'b1;
        return r;
    endfunction

    // Keep the last travel direction when work lies both ways; pending bits never
    // exceed TOP_FLOOR, so a move past either end can never be chosen.
    function automatic state_t route(input logic [9:1] p, input logic [3:0] f, input logic up_last);
        logic up, dn;
        up = any_above(p, f);
        dn = any_below(p, f);
        if (up && (up_last || !dn)) return MOVE_UP;
        if (dn) return MOVE_DOWN;
        return IDLE;
    endfunction

    logic [3:1] sync_q;
    logic [4:1] bcd1_q, bcd2_q;
    state_t     state_q, state_d;
    logic [3:0] floor_q, floor_d, next_f;
    logic [7:0] timer_q, timer_d;
    logic [9:1] pend_q, pend_d;
    logic       up_last_q, up_last_d;
    logic       mv_up_q, mv_dn_q, door_q;

    logic key_evt, key_floor, key_open, key_close, at_floor_key, parked;

    assign key_evt      = sync_q[2] & ~sync_q[3];
    assign key_floor    = key_evt && (bcd2_q != 4'd0) && (bcd2_q <= TOP_FLOOR);
    assign key_open     = key_evt && (bcd2_q == 4'd10);
    assign key_close    = key_evt && (bcd2_q == 4'd11);
    assign at_floor_key = key_floor && (bcd2_q == floor_q);
    assign parked       = (state_q == IDLE) || (state_q == DOOR_OPEN);

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        timer_d   = timer_q;
        pend_d    = pend_q;
        up_last_d = up_last_q;
        next_f    = floor_q;
        if (key_floor && !(parked && at_floor_key))
            pend_d = pend_d | onehot(bcd2_q);
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (key_open || at_floor_key) state_d = DOOR_OPEN;
                else                          state_d = route(pend_d, floor_q, up_last_q);
            end
            MOVE_UP, MOVE_DOWN: begin
                if (timer_q == TRAVEL_LAST) begin
                    timer_d = '0;
                    next_f  = (state_q == MOVE_UP) ? floor_q + 4'd1 : floor_q - 4'd1;
                    floor_d = next_f;
                    // A key for the arrival floor was merged above, so it is cleared here too.
                    if (|(pend_d & onehot(next_f))) begin
                        pend_d  = pend_d & ~onehot(next_f);
                        state_d = DOOR_OPEN;
                    end else begin
                        state_d = route(pend_d, next_f, up_last_q);
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            DOOR_OPEN: begin
                if (key_open || at_floor_key) begin
                    timer_d = '0;
                end else if (key_close || timer_q == DOOR_LAST) begin
                    timer_d = '0;
                    state_d = route(pend_d, floor_q, up_last_q);
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
        endcase
        if (state_d == MOVE_UP)   up_last_d = 1'b1;
        if (state_d == MOVE_DOWN) up_last_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q    <= '0;
            bcd1_q    <= '0;
            bcd2_q    <= '0;
            state_q   <= IDLE;
            floor_q   <= 4'd1;
            timer_q   <= '0;
            pend_q    <= '0;
            up_last_q <= 1'b1;
            mv_up_q   <= 1'b0;
            mv_dn_q   <= 1'b0;
            door_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[2:1], my_clock};
            bcd1_q    <= BCD_input;
            bcd2_q    <= bcd1_q;
            state_q   <= state_d;
            floor_q   <= floor_d;
            timer_q   <= timer_d;
            pend_q    <= pend_d;
            up_last_q <= up_last_d;
            mv_up_q   <= (state_d == MOVE_UP);
            mv_dn_q   <= (state_d == MOVE_DOWN);
            door_q    <= (state_d == DOOR_OPEN);
        end
    end

    assign current_floor = floor_q;
    assign moving_up     = mv_up_q;
    assign moving_down   = mv_dn_q;
    assign door_open     = door_q;
    assign pending       = pend_q;

`ifdef MANAGEMENT_SEG7_EN
    always_comb begin
        case (floor_q)
            4'd0:    seg_out = 7'b1000000;
            4'd1:    seg_out = 7'b1111001;
            4'd2:    seg_out = 7'b0100100;
            4'd3:    seg_out = 7'b0110000;
            4'd4:    seg_out = 7'b0011001;
            4'd5:    seg_out = 7'b0010010;
            4'd6:    seg_out = 7'b0000010;
            4'd7:    seg_out = 7'b1111000;
            4'd8:    seg_out = 7'b0000000;
            4'd9:    seg_out = 7'b0010000;
            default: seg_out = 7'b1111111;
        endcase
    end
`else
    assign seg_out = '1;
`endif

endmodule

// File: tb/tb_management.sv
// Directed bench for management: expected status words are queued as stimulus is
// applied and checked against the DUT at the matching sample point.
module tb_management;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       my_clock = 1'b0;
    logic [4:1] BCD_input = 4'd0;
    logic [3:0] current_floor;
    logic       moving_up, moving_down, door_open;
    logic [9:1] pending;
    logic [6:0] seg_out;

    management #(.NUM_FLOORS(9), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
        .CLK(CLK), .RST(RST), .my_clock(my_clock), .BCD_input(BCD_input),
        .current_floor(current_floor), .moving_up(moving_up), .moving_down(moving_down),
        .door_open(door_open), .pending(pending), .seg_out(seg_out)
    );

    always #5 CLK = ~CLK;

`ifdef MANAGEMENT_SEG7_EN
    localparam logic [6:0] SEG1 = 7'b1111001, SEG3 = 7'b0110000, SEG5 = 7'b0010010;
`else
    localparam logic [6:0] SEG1 = 7'h7F, SEG3 = 7'h7F, SEG5 = 7'h7F;
`endif

    typedef struct {string tag; bit is_seg; logic [15:0] exp;} exp_t;
    exp_t sb[$];
    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] status;
    assign status = {current_floor, moving_up, moving_down, door_open, pending};

    function automatic logic [9:1] pb(input int n);
        logic [9:1] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] st(input int f, input logic u, input logic d,
                                       input logic o, input logic [9:1] p);
        return {4'(f), u, d, o, p};
    endfunction

    task automatic push(input string tag, input logic [15:0] e);
        exp_t x;
        x.tag = tag; x.is_seg = 1'b0; x.exp = e;
        sb.push_back(x);
    endtask

    task automatic push_seg(input string tag, input logic [6:0] e);
        exp_t x;
        x.tag = tag; x.is_seg = 1'b1; x.exp = {9'd0, e};
        sb.push_back(x);
    endtask

    task automatic check();
        exp_t x;
        logic [15:0] obs;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            x = sb.pop_front();
            obs = x.is_seg ? {9'd0, seg_out} : status;
            assert (obs === x.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Returns just after the edge on which the key event is acted upon.
    task automatic press(input logic [3:0] code);
        my_clock = 1'b0;
        tick(1);
        BCD_input = code;
        my_clock  = 1'b1;
        tick(3);
        my_clock  = 1'b0;
        BCD_input = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(2);
        RST = 1'b0;
        push("reset", st(1, 0, 0, 0, '0)); check();
        push_seg("seg_floor1", SEG1); check();

        push("close_idle", st(1, 0, 0, 0, '0)); press(4'd11); check();
        push("key0_ignored", st(1, 0, 0, 0, '0)); press(4'd0); check();

        push("same_floor_open", st(1, 0, 0, 1, '0)); press(4'd1); check();
        push("same_floor_hold", st(1, 0, 0, 1, '0)); tick(2); check();
        push("same_floor_close", st(1, 0, 0, 0, '0)); tick(1); check();

        push("req3_start", st(1, 1, 0, 0, pb(3))); press(4'd3); check();
        push("req3_pre_step", st(1, 1, 0, 0, pb(3))); tick(3); check();
        push("req3_floor2", st(2, 1, 0, 0, pb(3))); tick(1); check();
        push("req3_arrive", st(3, 0, 0, 1, '0)); tick(4); check();
        push("req3_door_hold", st(3, 0, 0, 1, '0)); tick(2); check();
        push("req3_idle", st(3, 0, 0, 0, '0)); tick(1); check();
        push_seg("seg_floor3", SEG3); check();

        push("up5_start", st(3, 1, 0, 0, pb(5))); press(4'd5); check();
        push("up5_req2_latched", st(4, 1, 0, 0, pb(5) | pb(2))); press(4'd2); check();
        push("up5_stop5", st(5, 0, 0, 1, pb(2))); tick(4); check();
        push("up5_turn_down", st(5, 0, 1, 0, pb(2))); tick(3); check();
        push("down_floor4", st(4, 0, 1, 0, pb(2))); tick(4); check();
        push("down_stop2", st(2, 0, 0, 1, '0)); tick(8); check();
        push("down_idle2", st(2, 0, 0, 0, '0)); tick(3); check();

        push("close_move", st(2, 1, 0, 0, pb(3))); press(4'd3); check();
        tick(1);
        push("close_in_door", st(3, 0, 0, 0, '0)); press(4'd11); check();

        push("same_cycle_start", st(3, 1, 0, 0, pb(5))); press(4'd5); check();
        push("same_cycle_arrive4", st(4, 0, 0, 1, pb(5))); press(4'd4); check();
        push("same_cycle_resume", st(4, 1, 0, 0, pb(5))); tick(3); check();
        push("same_cycle_stop5", st(5, 0, 0, 1, '0)); tick(4); check();
        push_seg("seg_floor5", SEG5); check();
        push("same_cycle_idle5", st(5, 0, 0, 0, '0)); tick(3); check();

        push("open_move_start", st(5, 1, 0, 0, pb(7))); press(4'd7); check();
        push("open_while_moving", st(6, 1, 0, 0, pb(7))); press(4'd10); check();
        push("open_move_stop7", st(7, 0, 0, 1, '0)); tick(4); check();
        push("open_move_idle7", st(7, 0, 0, 0, '0)); tick(3); check();
        push("key12_ignored", st(7, 0, 0, 0, '0)); press(4'd12); check();

        push("top_req9", st(7, 1, 0, 0, pb(9))); press(4'd9); check();
        push("top_floor8", st(8, 1, 0, 0, pb(9))); tick(5); check();
        RST = 1'b1;
        push("reset_in_travel", st(1, 0, 0, 0, '0)); tick(1); check();
        RST = 1'b0;
        push("reset_discard", st(1, 0, 0, 0, '0)); tick(10); check();
        push_seg("seg_after_reset", SEG1); check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
